input_controller: RTL and testbench

- Upstream stage of the player module. Conditions raw push-buttons into per-simulation-tick movement and jump commands.
- Per button: synchronises the input, then debounces it with a per-button FSM.
- Horizontal intent is sampled once per sim_tick.
- Jump presses go to the player through a level req/ack handshake, so no press is lost between slow simulation ticks.

---
 rtl/sk_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 82 ++++++++
 rtl/input_controller.sv | 89 ++++++++
 tb/tb_input_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sk_pkg.sv
// Shared definitions for the input conditioning path: move encodings and debouncer states.
package sk_pkg;

    localparam logic [1:0] MOVE_NONE  = 2'b00;
    localparam logic [1:0] MOVE_LEFT  = 2'b01;
    localparam logic [1:0] MOVE_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        DbIdle     = 2'b00,
        DbChkPress = 2'b01,
        DbHeld     = 2'b10,
        DbChkRel   = 2'b11
    } dbState_e;

    // Opposing or absent directions both resolve to no movement.
    function automatic logic [1:0] moveFromLevels(input logic left, input logic right);
        if (left && !right) begin
            return MOVE_LEFT;
        end else if (right && !left) begin
            return MOVE_RIGHT;
        end
        return MOVE_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser followed by a 4-state debounce FSM.
// level is high in Held/ChkRel; rise pulses for one cycle on entry to Held.
module btn_debounce
    import sk_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    logic [1:0]      syncQ;
    logic            sync;
    dbState_e        state;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cntNext;

    assign sync    = syncQ[1];
    // The cycle that leaves Idle/Held counts as the first stable cycle, so the
    // change is accepted when the incremented count reaches DB_CYCLES-1.
    assign cntNext = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ <= '0;
            state <= DbIdle;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            syncQ <= {syncQ[0], raw};
            rise  <= 1'b0;
            case (state)
                DbIdle: begin
                    if (sync) begin
                        state <= DbChkPress;
                        cnt   <= '0;
                    end
                end
                DbChkPress: begin
                    if (!sync) begin
                        state <= DbIdle;
                        cnt   <= '0;
                    end else if (cntNext == CntLast) begin
                        state <= DbHeld;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cntNext;
                    end
                end
                DbHeld: begin
                    if (!sync) begin
                        state <= DbChkRel;
                        cnt   <= '0;
                    end
                end
                DbChkRel: begin
                    if (sync) begin
                        state <= DbHeld;
                        cnt   <= '0;
                    end else if (cntNext == CntLast) begin
                        state <= DbIdle;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cntNext;
                    end
                end
                default: state <= DbIdle;
            endcase
        end
    end

endmodule

// File: rtl/input_controller.sv
// Button conditioning for the player: per-tick move direction and a req/ack jump handshake.
// Define JUMP_BUFFER_EN to let an unissued pending jump expire after JUMP_BUF_TICKS ticks.
module input_controller
    import sk_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter int unsigned JUMP_BUF_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sim_tick,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       jump_ack,
    output logic [1:0] move_dir,
    output logic       jump_req,
    output logic [2:0] btn_db
);

    logic       lvlL, lvlR, lvlU;
    logic       riseU;
    logic [1:0] unusedRise;
    logic       pending;
    logic       issue;
    logic       expire;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDbL (
        .clk(clk), .rst_n(rst_n), .raw(btn_l), .level(lvlL), .rise(unusedRise[0])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDbR (
        .clk(clk), .rst_n(rst_n), .raw(btn_r), .level(lvlR), .rise(unusedRise[1])
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDbU (
        .clk(clk), .rst_n(rst_n), .raw(btn_u), .level(lvlU), .rise(riseU)
    );

    assign btn_db = {lvlU, lvlR, lvlL};
    // Only offer a new jump once the previous one has been acknowledged.
    assign issue  = sim_tick && pending && !jump_req;

`ifdef JUMP_BUFFER_EN
    localparam int unsigned TickW = (JUMP_BUF_TICKS > 1) ? $clog2(JUMP_BUF_TICKS) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(JUMP_BUF_TICKS - 1);

    logic [TickW-1:0] tickCnt;

    assign expire = sim_tick && pending && !issue && (tickCnt == TickLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickCnt <= '0;
        end else if (riseU && !pending) begin
            tickCnt <= '0;
        end else if (sim_tick && pending && !issue && !expire) begin
            tickCnt <= tickCnt + 1'b1;
        end
    end
`else
    logic unusedBufTicks;

    assign unusedBufTicks = ^JUMP_BUF_TICKS;
    assign expire         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_dir <= MOVE_NONE;
            jump_req <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (sim_tick) begin
                move_dir <= moveFromLevels(lvlL, lvlR);
            end
            if (jump_req && jump_ack) begin
                jump_req <= 1'b0;
            end else if (issue) begin
                jump_req <= 1'b1;
            end
            // One-deep: a press arriving while one is already pending is dropped.
            if (riseU && !pending) begin
                pending <= 1'b1;
            end else if (issue || expire) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with a behavioural model checked every cycle.
module tb_input_controller;
    import sk_pkg::*;

    localparam int DB  = 4;
    localparam int JBT = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       sim_tick = 1'b0;
    logic       btn_l    = 1'b0;
    logic       btn_r    = 1'b0;
    logic       btn_u    = 1'b0;
    logic       jump_ack = 1'b0;
    logic [1:0] move_dir;
    logic       jump_req;
    logic [2:0] btn_db;

    int nChecks = 0;
    int nFails  = 0;

    input_controller #(.DB_CYCLES(DB), .JUMP_BUF_TICKS(JBT)) dut (
        .clk(clk), .rst_n(rst_n), .sim_tick(sim_tick), .btn_l(btn_l), .btn_r(btn_r),
        .btn_u(btn_u), .jump_ack(jump_ack), .move_dir(move_dir), .jump_req(jump_req),
        .btn_db(btn_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Free-running tick: one clk-wide pulse every 20 cycles.
    int tickCnt = 0;
    always @(negedge clk) begin
        tickCnt  = (tickCnt == 19) ? 0 : tickCnt + 1;
        sim_tick = (tickCnt == 19);
    end

    // Behavioural model.
    logic [2:0] mS1 = '0, mS2 = '0, mLvl = '0, mRise = '0;
    int         mRun[3] = '{0, 0, 0};
    logic [1:0] mMove = MOVE_NONE;
    logic       mReq = 1'b0, mPend = 1'b0, mPendOld, mIssue;
    int         mWait = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mS1 = '0; mS2 = '0; mLvl = '0; mRise = '0;
            mRun = '{0, 0, 0};
            mMove = MOVE_NONE; mReq = 1'b0; mPend = 1'b0; mWait = 0;
        end else begin
            mPendOld = mPend;
            mIssue   = sim_tick && mPend && !mReq;
            if (sim_tick) begin
                if (mLvl[0] && !mLvl[1])      mMove = MOVE_LEFT;
                else if (mLvl[1] && !mLvl[0]) mMove = MOVE_RIGHT;
                else                          mMove = MOVE_NONE;
            end
            if (mReq && jump_ack) mReq = 1'b0;
            else if (mIssue)      mReq = 1'b1;
            if (mIssue) begin
                mPend = 1'b0;
            end else if (mPend && sim_tick) begin
                mWait++;
`ifdef JUMP_BUFFER_EN
                if (mWait >= JBT) mPend = 1'b0;
`endif
            end
            if (mRise[2] && !mPendOld) begin
                mPend = 1'b1;
                mWait = 0;
            end
            for (int b = 0; b < 3; b++) begin
                mRise[b] = 1'b0;
                if (mS2[b] != mLvl[b]) mRun[b]++;
                else                   mRun[b] = 0;
                if (mRun[b] == DB) begin
                    mLvl[b]  = ~mLvl[b];
                    mRun[b]  = 0;
                    mRise[b] = mLvl[b];
                end
            end
            mS2 = mS1;
            mS1 = {btn_u, btn_r, btn_l};
        end
        #1;
        check("move_dir", 32'(move_dir), 32'(mMove));
        check("jump_req", 32'(jump_req), 32'(mReq));
        check("btn_db", 32'(btn_db), 32'(mLvl));
    end

    // Request pulse counter and length of the most recent completed pulse.
    int  reqPulses = 0, curLen = 0, lastLen = 0;
    logic prevReq = 1'b0;
    always @(posedge clk) begin
        #2;
        if (jump_req && !prevReq) begin
            reqPulses++;
            curLen = 0;
        end
        if (jump_req) curLen++;
        if (!jump_req && prevReq) lastLen = curLen;
        prevReq = jump_req;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReqHigh(input string name);
        int n = 0;
        while (jump_req !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(jump_req), 32'd1);
    endtask

    // Returns 1 time unit after the edge that sampled a tick.
    task automatic afterTick();
        int n = 0;
        @(posedge clk);
        while (sim_tick !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    task automatic ack();
        @(negedge clk);
        jump_ack = 1'b1;
        @(negedge clk);
        jump_ack = 1'b0;
    endtask

    task automatic pulseU();
        btn_u = 1'b0;
        cyc(8);
        btn_u = 1'b1;
        cyc(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        check("reset_move", 32'(move_dir), 32'(MOVE_NONE));
        check("reset_req", 32'(jump_req), 32'd0);
        check("reset_db", 32'(btn_db), 32'd0);
        rst_n = 1'b1;
        cyc(4);

        // 3-cycle glitch on L is rejected.
        btn_l = 1'b1;
        cyc(3);
        btn_l = 1'b0;
        cyc(10);
        check("glitch_db", 32'(btn_db), 32'd0);
        afterTick();
        check("glitch_move", 32'(move_dir), 32'(MOVE_NONE));

        // Accepted press: level rises 6 edges after the raw edge.
        @(negedge clk);
        btn_l = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("l_before_db", 32'(btn_db[0]), 32'd0);
        @(posedge clk);
        #1;
        check("l_after_db", 32'(btn_db[0]), 32'd1);
        afterTick();
        check("move_left", 32'(move_dir), 32'(MOVE_LEFT));

        // Both held -> none; release L -> right.
        @(negedge clk);
        btn_r = 1'b1;
        cyc(10);
        afterTick();
        check("move_both", 32'(move_dir), 32'(MOVE_NONE));
        @(negedge clk);
        btn_l = 1'b0;
        cyc(10);
        afterTick();
        check("move_right", 32'(move_dir), 32'(MOVE_RIGHT));
        @(negedge clk);
        btn_r = 1'b0;
        cyc(10);

        // Single jump, acked after 5 cycles, U held afterwards.
        btn_u = 1'b1;
        waitReqHigh("req1_rise");
        cyc(5);
        jump_ack = 1'b1;
        @(negedge clk);
        jump_ack = 1'b0;
        cyc(60);
        check("req1_len", 32'(lastLen), 32'd5);
        check("held_one_req", 32'(reqPulses), 32'd1);
        btn_u = 1'b0;
        cyc(10);

        // Second press queues behind an open request; a third is dropped.
        btn_u = 1'b1;
        waitReqHigh("req2_rise");
        cyc(2);
        pulseU();
        pulseU();
        btn_u = 1'b0;
        check("req2_still_high", 32'(jump_req), 32'd1);
        ack();
        waitReqHigh("req3_rise");
        ack();
        cyc(60);
        check("two_reqs_only", 32'(reqPulses), 32'd3);

        // Asynchronous reset while a request is open.
        btn_r = 1'b1;
        cyc(10);
        afterTick();
        check("pre_reset_move", 32'(move_dir), 32'(MOVE_RIGHT));
        @(negedge clk);
        btn_u = 1'b1;
        waitReqHigh("req4_rise");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_req", 32'(jump_req), 32'd0);
        check("async_move", 32'(move_dir), 32'(MOVE_NONE));
        btn_u = 1'b0;
        btn_r = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(80);
        check("no_spurious_req", 32'(reqPulses), 32'd4);
        check("post_reset_move", 32'(move_dir), 32'(MOVE_NONE));

`ifdef JUMP_BUFFER_EN
        // Pending press ages out while the open request is not acked.
        btn_u = 1'b1;
        waitReqHigh("req5_rise");
        cyc(2);
        pulseU();
        btn_u = 1'b0;
        afterTick();
        afterTick();
        afterTick();
        ack();
        cyc(60);
        check("buffer_expired", 32'(reqPulses), 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
